// File: rtl/plane_fetcher_if.sv
// Video plane fetch bus: line timing, SRAM slice handshake and pixel outputs.
// master = timing/SRAM side driving the fetcher, slave = the fetcher itself.
interface plane_fetcher_if;
   logic        ce_pixel;
   logic        video_slice;
   logic        pipe_ab;
   logic        line_start;
   logic        line_active;
   logic [7:0]  fb_row;
   logic [7:0]  SRAM_DQ;
   logic [15:0] SRAM_ADDR;
   logic [3:0]  coloridx;
   logic        borderx;
   logic        underrun;

   modport master (
      output ce_pixel, video_slice, pipe_ab, line_start, line_active, fb_row, SRAM_DQ,
      input  SRAM_ADDR, coloridx, borderx, underrun
   );

   modport slave (
      input  ce_pixel, video_slice, pipe_ab, line_start, line_active, fb_row, SRAM_DQ,
      output SRAM_ADDR, coloridx, borderx, underrun
   );
endinterface

// File: rtl/plane_fetcher.sv
// Fetches 4 bitplanes per byte column from SRAM and shifts them out as 4-bit pixels.
// Pixel appears one clk24 after its load edge; a column load with missing planes shows 0s and pulses underrun.
module plane_fetcher #(
   parameter int LEAD    = 64,
   parameter int COLUMNS = 32
) (
   input  logic         clk24,
   input  logic         rst_n,
   plane_fetcher_if.slave bus
);
   localparam int TW = $clog2(LEAD + 8 * COLUMNS + 1) + 1;
   localparam int CW = $clog2(COLUMNS + 1);

   typedef enum logic [1:0] {IDLE, FETCH, FULL, DONE} state_t;

   state_t         r_state, w_next;
   logic [TW-1:0]  r_tick;
   logic [CW-1:0]  r_col;
   logic [1:0]     r_plane;
   logic           r_issued;
   logic [7:0]     r_row;
   logic [7:0]     r_buf [4];
   logic [7:0]     r_sh  [4];
   logic           r_border;
   logic           r_underrun;
   logic [15:0]    r_addr;

   logic           w_fetching;
   logic [TW-1:0]  w_load_tick;
   logic [TW-1:0]  w_tick_next;
   logic           w_load;
   logic           w_last_col;
   logic           w_addr_ph;
   logic           w_data_ph;
   logic           w_in_active;
   logic [4:0]     w_col5;

   assign w_fetching  = (r_state == FETCH) || (r_state == FULL);
   assign w_load_tick = TW'(LEAD - 1) + TW'({r_col, 3'b000});
   assign w_load      = bus.ce_pixel && w_fetching && (r_tick == w_load_tick);
   assign w_last_col  = (r_col == CW'(COLUMNS - 1));
   // A column load owns its edge: slice events landing on it are dropped.
   assign w_addr_ph   = bus.video_slice && !bus.pipe_ab && (r_state == FETCH) && !w_load;
   assign w_data_ph   = bus.video_slice && bus.pipe_ab && r_issued && !w_load;
   assign w_tick_next = (r_tick == '1) ? r_tick : r_tick + 1'b1;
   assign w_in_active = (w_tick_next >= TW'(LEAD)) && (w_tick_next < TW'(LEAD + 8 * COLUMNS));
   assign w_col5      = 5'(r_col);

   always_ff @(posedge clk24) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (bus.line_start)
         w_next = bus.line_active ? FETCH : IDLE;
      else if (w_load)
         w_next = w_last_col ? DONE : FETCH;
      else if (w_data_ph && (r_plane == 2'd3))
         w_next = FULL;
   end

   always_ff @(posedge clk24) begin
      if (!rst_n) begin
         r_tick     <= '0;
         r_col      <= '0;
         r_plane    <= '0;
         r_issued   <= 1'b0;
         r_row      <= '0;
         r_border   <= 1'b1;
         r_underrun <= 1'b0;
         r_addr     <= '0;
         for (int p = 0; p < 4; p++) begin
            r_buf[p] <= '0;
            r_sh[p]  <= '0;
         end
      end else begin
         r_underrun <= 1'b0;
         if (bus.line_start) begin
            r_row    <= bus.fb_row;
            r_tick   <= '0;
            r_col    <= '0;
            r_plane  <= '0;
            r_issued <= 1'b0;
            r_border <= 1'b1;
            for (int p = 0; p < 4; p++) begin
               r_buf[p] <= '0;
               r_sh[p]  <= '0;
            end
         end else begin
            if (bus.ce_pixel) begin
               r_tick   <= w_tick_next;
               // The border follows the tick count alone so the last column drains in DONE.
               r_border <= (r_state == IDLE) || !w_in_active;
            end
            if (w_load) begin
               for (int p = 0; p < 4; p++)
                  r_sh[p] <= ((r_state == FULL) || (2'(p) < r_plane)) ? r_buf[p] : 8'h00;
               r_plane    <= '0;
               r_issued   <= 1'b0;
               r_col      <= r_col + 1'b1;
               r_underrun <= (r_state == FETCH);
            end else if (bus.ce_pixel) begin
               for (int p = 0; p < 4; p++)
                  r_sh[p] <= {r_sh[p][6:0], 1'b0};
            end
            if (w_addr_ph) begin
               r_addr   <= {1'b1, r_plane, w_col5, r_row};
               r_issued <= 1'b1;
            end
            if (w_data_ph) begin
               r_buf[r_plane] <= bus.SRAM_DQ;
               r_issued       <= 1'b0;
               r_plane        <= r_plane + 1'b1;
            end
         end
      end
   end

   assign bus.SRAM_ADDR = r_addr;
   assign bus.borderx   = r_border;
   assign bus.underrun  = r_underrun;
   assign bus.coloridx  = r_border ? 4'h0 : {r_sh[3][7], r_sh[2][7], r_sh[1][7], r_sh[0][7]};
endmodule
